// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame assembler: FSM state encoding,
// byte width and the default frame start marker.
package uart_frame_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAY,
        CHK,
        HOLD
    } state_t;

endpackage

// File: rtl/uart_frame_assembler_if.sv
// Byte-strobe input from the UART receiver and valid/ready frame output toward the
// hashing core. The slave modport is the assembler's view, the master modport the driver's.
interface uart_frame_assembler_if #(
    parameter int MAX_BYTES = 80
);
    logic                                       rx_valid;
    logic [uart_frame_pkg::BYTE_W-1:0]          rx_data;
    logic                                       rx_idle;
    logic                                       frame_valid;
    logic                                       frame_ready;
    logic [MAX_BYTES*uart_frame_pkg::BYTE_W-1:0] frame_data;
    logic [7:0]                                 frame_len;
    logic                                       chk_err;
    logic                                       len_err;
    logic                                       overrun;

    modport master (
        output rx_valid, rx_data, rx_idle, frame_ready,
        input  frame_valid, frame_data, frame_len, chk_err, len_err, overrun
    );

    modport slave (
        input  rx_valid, rx_data, rx_idle, frame_ready,
        output frame_valid, frame_data, frame_len, chk_err, len_err, overrun
    );

endinterface

// File: rtl/uart_frame_assembler.sv
// Hunts for SYNC_BYTE, collects a length-prefixed XOR-checked frame and holds it for a
// valid/ready consumer. Define FRAME_TIMEOUT_EN to abort partial frames on a rising rx_idle.
module uart_frame_assembler
    import uart_frame_pkg::*;
#(
    parameter int                MAX_BYTES = 80,
    parameter logic [BYTE_W-1:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_frame_assembler_if.slave  bus
);

    localparam int              DATA_W  = MAX_BYTES * BYTE_W;
    localparam int              CNT_W   = $clog2(MAX_BYTES + 1);
    localparam int              IDX_W   = $clog2(DATA_W);
    localparam logic [7:0]      MAX_LEN = 8'(MAX_BYTES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [BYTE_W-1:0]     r_xor;
    logic [BYTE_W-1:0]     w_xor_nxt;
    logic [DATA_W-1:0]     r_frame_data;
    logic [DATA_W-1:0]     w_frame_data_nxt;
    logic [7:0]            r_frame_len;
    logic [7:0]            w_frame_len_nxt;
    logic                  r_chk_err;
    logic                  w_chk_err_nxt;
    logic                  r_len_err;
    logic                  w_len_err_nxt;
    logic                  r_overrun;
    logic                  w_overrun_nxt;

    logic                  w_len_ok;
    logic                  w_last_byte;
    logic [IDX_W-1:0]      w_bit_idx;
    logic                  w_abort;

    assign w_len_ok    = (bus.rx_data != '0) && (bus.rx_data <= MAX_LEN);
    assign w_last_byte = (8'(r_cnt) == (r_frame_len - 8'd1));
    assign w_bit_idx   = IDX_W'(r_cnt) * IDX_W'(BYTE_W);

`ifdef FRAME_TIMEOUT_EN
    logic r_idle_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_d <= 1'b0;
        end else begin
            r_idle_d <= bus.rx_idle;
        end
    end

    // Line going idle while a frame is only partly received means the sender gave up.
    assign w_abort = bus.rx_idle && !r_idle_d &&
                     ((r_state == LEN) || (r_state == PAY) || (r_state == CHK));
`else
    logic w_unused_idle;

    assign w_unused_idle = bus.rx_idle;
    assign w_abort       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no branch of the case can infer a latch.
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_xor_nxt        = r_xor;
        w_frame_data_nxt = r_frame_data;
        w_frame_len_nxt  = r_frame_len;
        w_chk_err_nxt    = 1'b0;
        w_len_err_nxt    = 1'b0;
        w_overrun_nxt    = 1'b0;

        if (w_abort) begin
            w_state_nxt   = HUNT;
            w_len_err_nxt = 1'b1;
        end else begin
            case (r_state)
                HUNT: begin
                    if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                        w_state_nxt = LEN;
                    end
                end
                LEN: begin
                    if (bus.rx_valid) begin
                        if (w_len_ok) begin
                            w_frame_len_nxt  = bus.rx_data;
                            w_xor_nxt        = bus.rx_data;
                            w_cnt_nxt        = '0;
                            w_frame_data_nxt = '0;
                            w_state_nxt      = PAY;
                        end else begin
                            w_len_err_nxt = 1'b1;
                            w_state_nxt   = HUNT;
                        end
                    end
                end
                PAY: begin
                    // A sync byte here is payload; there is no mid-frame resynchronisation.
                    if (bus.rx_valid) begin
                        w_frame_data_nxt[w_bit_idx +: BYTE_W] = bus.rx_data;
                        w_xor_nxt = r_xor ^ bus.rx_data;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (w_last_byte) begin
                            w_state_nxt = CHK;
                        end
                    end
                end
                CHK: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == r_xor) begin
                            w_state_nxt = HOLD;
                        end else begin
                            w_chk_err_nxt = 1'b1;
                            w_state_nxt   = HUNT;
                        end
                    end
                end
                HOLD: begin
                    // The receiver cannot be stalled, so bytes arriving now are dropped and flagged.
                    w_overrun_nxt = bus.rx_valid;
                    if (bus.frame_ready) begin
                        w_state_nxt = HUNT;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_xor        <= '0;
            // NOTE: frame_data is a flat flop register, not a RAM, so clearing it on reset is legal and cheap to reason about.
            r_frame_data <= '0;
            r_frame_len  <= '0;
            r_chk_err    <= 1'b0;
            r_len_err    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_xor        <= w_xor_nxt;
            r_frame_data <= w_frame_data_nxt;
            r_frame_len  <= w_frame_len_nxt;
            r_chk_err    <= w_chk_err_nxt;
            r_len_err    <= w_len_err_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign bus.frame_valid = (r_state == HOLD);
    assign bus.frame_data  = r_frame_data;
    assign bus.frame_len   = r_frame_len;
    assign bus.chk_err     = r_chk_err;
    assign bus.len_err     = r_len_err;
    assign bus.overrun     = r_overrun;

endmodule
